// File: rtl/fpmul_pkg.sv
// Shared definitions for the sequential floating-point multiplier:
// FSM state encoding and format-dependent constant helpers.
package fpmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic int bias_f(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Format constants are built in a 64-bit container; callers slice to W.
  function automatic logic [63:0] inf_f(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] qnan_f(input int exp_w, input int man_w);
    logic [63:0] v;
    v = inf_f(exp_w, man_w);
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fpmul_round.sv
// Combinational normalise / round-to-nearest-even / pack stage.
// Takes the raw significand product and biased exponent sum, returns the packed result.
module fpmul_round
  import fpmul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      sign_i,
  input  logic signed [EXP_W+1:0]   exp_i,
  input  logic [2*MAN_W+1:0]        prod_i,
  output logic [EXP_W+MAN_W:0]      result_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int ES_W   = EXP_W + 2;
  localparam int PROD_W = 2 * MAN_W + 2;
  localparam logic signed [ES_W-1:0] EXP_MAX = ES_W'((1 << EXP_W) - 1);
  localparam logic [63:0] INF_L = inf_f(EXP_W, MAN_W);
  localparam logic [EXP_W+MAN_W-1:0] INF_MAG = INF_L[EXP_W+MAN_W-1:0];

  logic [PROD_W-2:0]       norm;
  logic [MAN_W-1:0]        frac;
  logic [MAN_W-1:0]        frac_r;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic                    carry;
  logic signed [ES_W-1:0]  exp_n;
  logic signed [ES_W-1:0]  exp_r;

  // NOTE: combinational logic uses blocking assignments and gives every output a default first, so no latch is inferred.
  always_comb begin
    // Product of two [1,2) significands lies in [1,4); the MSB selects the binade.
    norm     = prod_i[PROD_W-1] ? prod_i[PROD_W-2:0] : {prod_i[PROD_W-3:0], 1'b0};
    exp_n    = prod_i[PROD_W-1] ? exp_i + ES_W'(1) : exp_i;
    frac     = norm[PROD_W-2 -: MAN_W];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + (MAN_W + 1)'(round_up);
    exp_r    = carry ? exp_n + ES_W'(1) : exp_n;

    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    result_o    = {sign_i, exp_r[EXP_W-1:0], frac_r};
    if (exp_r >= EXP_MAX) begin
      result_o   = {sign_i, INF_MAG};
      overflow_o = 1'b1;
    end else if (exp_r[ES_W-1] || (exp_r == '0)) begin
      result_o    = {sign_i, {(EXP_W + MAN_W){1'b0}}};
      underflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/fpmul_seq.sv
// Multi-cycle IEEE-754 multiplier: shift-add mantissa engine retiring BITS_PER_CYC
// multiplier bits per cycle, RNE rounding, canonical NaN, flush-to-zero.
module fpmul_seq
  import fpmul_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int BITS_PER_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   exception,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int ES_W   = EXP_W + 2;
  localparam int N      = SIG_W / BITS_PER_CYC;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [ES_W-1:0] BIAS = ES_W'(bias_f(EXP_W));
  localparam logic [63:0] QNAN_L = qnan_f(EXP_W, MAN_W);
  localparam logic [63:0] INF_L  = inf_f(EXP_W, MAN_W);
  localparam logic [W-1:0]   QNAN    = QNAN_L[W-1:0];
  localparam logic [W-2:0]   INF_MAG = INF_L[W-2:0];

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } operand_t;

  function automatic operand_t unpack_op(input logic [W-1:0] x);
    operand_t o;
    o.sign    = x[W-1];
    o.exp     = x[W-2 -: EXP_W];
    o.is_zero = (o.exp == '0);
    o.is_inf  = (o.exp == '1) && (x[MAN_W-1:0] == '0);
    o.is_nan  = (o.exp == '1) && (x[MAN_W-1:0] != '0);
    // Denormals are flushed: a zero exponent field drops the fraction entirely.
    o.sig     = o.is_zero ? '0 : {1'b1, x[MAN_W-1:0]};
    return o;
  endfunction

  state_t                  state_q,   state_d;
  logic [W-1:0]            a_q,       a_d;
  logic [W-1:0]            b_q,       b_d;
  logic                    sign_q,    sign_d;
  logic signed [ES_W-1:0]  exp_q,     exp_d;
  logic [PROD_W-1:0]       mcand_q,   mcand_d;
  logic [SIG_W-1:0]        mplier_q,  mplier_d;
  logic [PROD_W-1:0]       prod_q,    prod_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    special_q, special_d;
  logic [W-1:0]            result_q,  result_d;
  logic                    exc_q,     exc_d;
  logic                    ovf_q,     ovf_d;
  logic                    unf_q,     unf_d;

  operand_t          op_a;
  operand_t          op_b;
  logic [PROD_W-1:0] partial;
  logic [W-1:0]      rnd_result;
  logic              rnd_ovf;
  logic              rnd_unf;

  fpmul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign_i      (sign_q),
    .exp_i       (exp_q),
    .prod_i      (prod_q),
    .result_o    (rnd_result),
    .overflow_o  (rnd_ovf),
    .underflow_o (rnd_unf)
  );

  always_comb begin
    op_a = unpack_op(a_q);
    op_b = unpack_op(b_q);

    partial = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end

    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    result_d  = result_q;
    exc_d     = exc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d    = op_a.sign ^ op_b.sign;
        exc_d     = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        special_d = 1'b1;
        // Specials skip MULT; NORM leaves their preset result untouched.
        state_d   = S_NORM;
        if (op_a.is_nan || op_b.is_nan ||
            (op_a.is_inf && op_b.is_zero) || (op_a.is_zero && op_b.is_inf)) begin
          result_d = QNAN;
          exc_d    = 1'b1;
        end else if (op_a.is_inf || op_b.is_inf) begin
          result_d = {sign_d, INF_MAG};
          exc_d    = 1'b1;
        end else if (op_a.is_zero || op_b.is_zero) begin
          result_d = {sign_d, {(W - 1){1'b0}}};
        end else begin
          special_d = 1'b0;
          exp_d     = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - BIAS;
          mcand_d   = PROD_W'(op_a.sig);
          mplier_d  = op_b.sig;
          prod_d    = '0;
          cnt_d     = CNT_W'(N - 1);
          state_d   = S_MULT;
        end
      end

      S_MULT: begin
        prod_d   = prod_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYC;
        mplier_d = mplier_q >> BITS_PER_CYC;
        if (cnt_q == '0) state_d = S_NORM;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      S_NORM: begin
        if (!special_q) begin
          result_d = rnd_result;
          ovf_d    = rnd_ovf;
          unf_d    = rnd_unf;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register, including the operand and product stores, is cleared by reset so no stale data survives an abandoned operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      special_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign exception = out_valid & exc_q;
  assign overflow  = out_valid & ovf_q;
  assign underflow = out_valid & unf_q;

endmodule
